// File: rtl/imem_resp.sv
// Instruction-memory responder: timed valid/ready slave in front of a
// word-addressed instruction store with a loader write port.
module imem_resp #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          DEPTH     = 32,
  parameter int          LATENCY   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [31:0]              req_addr,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [31:0]              rsp_data,
  output logic                     rsp_err,
  input  logic                     mem_we,
  input  logic [$clog2(DEPTH)-1:0] mem_waddr,
  input  logic [31:0]              mem_wdata
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [31:0] SPAN = 32'(DEPTH * 4);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [2:0]    cnt;
  logic [2:0]    cnt_n;
  logic          load;

  logic [31:0]   mem [DEPTH];

  logic [31:0]   off;
  logic [AW-1:0] idx_now;
  logic [AW-1:0] idx_q;
  logic [AW-1:0] rd_idx;
  logic          err_now;
  logic          err_q;
  logic          rd_err;

  assign off     = req_addr - BASE_ADDR;
  assign idx_now = off[AW+1:2];
  assign err_now = (req_addr[1:0] != 2'b00) || (off >= SPAN);

  // LATENCY=1 captures straight from the request on the accept edge
  assign rd_idx = (state == IDLE) ? idx_now : idx_q;
  assign rd_err = (state == IDLE) ? err_now : err_q;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    load      = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (LATENCY == 1) begin
            state_n = RESP;
            load    = 1'b1;
          end else begin
            state_n = WAIT;
            cnt_n   = 3'(LATENCY - 2);
          end
        end
      end
      WAIT: begin
        if (cnt == 3'd0) begin
          state_n = RESP;
          load    = 1'b1;
        end else begin
          cnt_n = cnt - 3'd1;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= 3'd0;
      idx_q    <= '0;
      err_q    <= 1'b0;
      rsp_data <= 32'd0;
      rsp_err  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (state == IDLE && req_valid) begin
        idx_q <= idx_now;
        err_q <= err_now;
      end
      if (load) begin
        rsp_data <= rd_err ? 32'd0 : mem[rd_idx];
        rsp_err  <= rd_err;
      end else if (state == RESP && rsp_ready) begin
        rsp_err <= 1'b0;
      end
    end
  end

  // store is deliberately outside the reset domain
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

endmodule

// File: tb/tb_imem_resp.sv
// Directed bench for imem_resp: three instances at LATENCY 2, 1 and 7
// sharing clock, reset and the store write port.
module tb_imem_resp;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid [3];
  logic        req_ready [3];
  logic [31:0] req_addr  [3];
  logic        rsp_valid [3];
  logic        rsp_ready [3];
  logic [31:0] rsp_data  [3];
  logic        rsp_err   [3];
  logic        mem_we    = 1'b0;
  logic [4:0]  mem_waddr = 5'd0;
  logic [31:0] mem_wdata = 32'd0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  imem_resp #(.LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_addr(req_addr[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_data(rsp_data[0]), .rsp_err(rsp_err[0]),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
  );

  imem_resp #(.LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_addr(req_addr[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_data(rsp_data[1]), .rsp_err(rsp_err[1]),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
  );

  imem_resp #(.LATENCY(7)) u_l7 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_addr(req_addr[2]),
    .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
    .rsp_data(rsp_data[2]), .rsp_err(rsp_err[2]),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
  );

  typedef struct {
    int          k;
    logic [31:0] addr;
    int          bp;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs [14];

  function automatic int lat_of(input int k);
    case (k)
      0:       return 2;
      1:       return 1;
      default: return 7;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic wr(input logic [4:0] idx, input logic [31:0] data);
    @(negedge clk);
    mem_we    = 1'b1;
    mem_waddr = idx;
    mem_wdata = data;
    @(negedge clk);
    mem_we    = 1'b0;
  endtask

  // Called at a negedge with instance k idle; returns at the negedge
  // right after the response handshake edge.
  task automatic do_req(input int k, input logic [31:0] addr, input int bp,
                        input logic [31:0] exp_data, input logic exp_err);
    int edges;
    logic [31:0] held;
    req_valid[k] = 1'b1;
    req_addr[k]  = addr;
    rsp_ready[k] = (bp == 0);
    check($sformatf("req_ready_idle[%0d]", k), 32'(req_ready[k]), 32'd1);
    @(negedge clk);
    req_valid[k] = 1'b0;
    req_addr[k]  = 32'hDEAD_0000;
    edges = 1;
    while (!rsp_valid[k] && edges < 20) begin
      @(negedge clk);
      edges++;
    end
    check($sformatf("latency[%0d] %h", k, addr), 32'(edges),
          32'(lat_of(k)));
    check($sformatf("data[%0d] %h", k, addr), rsp_data[k], exp_data);
    check($sformatf("err[%0d] %h", k, addr), 32'(rsp_err[k]),
          32'(exp_err));
    held = rsp_data[k];
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(rsp_valid[k]), 32'd1);
      check("bp_data", rsp_data[k], held);
      check("bp_req_ready", 32'(req_ready[k]), 32'd0);
    end
    rsp_ready[k] = 1'b1;
    @(negedge clk);
    rsp_ready[k] = 1'b0;
    check($sformatf("post_valid[%0d]", k), 32'(rsp_valid[k]), 32'd0);
    check($sformatf("post_err[%0d]", k), 32'(rsp_err[k]), 32'd0);
    check($sformatf("post_ready[%0d]", k), 32'(req_ready[k]), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      req_valid[i] = 1'b0;
      req_addr[i]  = 32'd0;
      rsp_ready[i] = 1'b0;
    end

    vecs[0]  = '{0, 32'h8000_0000, 0, 32'h0050_0313, 1'b0};
    vecs[1]  = '{0, 32'h8000_0004, 5, 32'h0010_0073, 1'b0};
    vecs[2]  = '{0, 32'h8000_0002, 0, 32'h0000_0000, 1'b1};
    vecs[3]  = '{0, 32'h8000_0080, 0, 32'h0000_0000, 1'b1};
    vecs[4]  = '{0, 32'h7FFF_FFFC, 0, 32'h0000_0000, 1'b1};
    vecs[5]  = '{0, 32'h8000_007C, 0, 32'hDEAD_BEEF, 1'b0};
    vecs[6]  = '{1, 32'h8000_0000, 0, 32'h0050_0313, 1'b0};
    vecs[7]  = '{1, 32'h8000_0004, 0, 32'h0010_0073, 1'b0};
    vecs[8]  = '{1, 32'h8000_0008, 0, 32'hAAAA_AAAA, 1'b0};
    vecs[9]  = '{1, 32'h8000_000C, 0, 32'h1234_5678, 1'b0};
    vecs[10] = '{2, 32'h8000_0000, 0, 32'h0050_0313, 1'b0};
    vecs[11] = '{2, 32'h8000_0004, 0, 32'h0010_0073, 1'b0};
    vecs[12] = '{2, 32'h8000_0008, 0, 32'hAAAA_AAAA, 1'b0};
    vecs[13] = '{2, 32'h8000_000C, 0, 32'h1234_5678, 1'b0};

    // store is loaded while reset is still asserted
    #2;
    check("rst_valid", 32'(rsp_valid[0]), 32'd0);
    check("rst_data", rsp_data[0], 32'd0);
    check("rst_err", 32'(rsp_err[0]), 32'd0);
    wr(5'd0, 32'h0050_0313);
    wr(5'd1, 32'h0010_0073);
    wr(5'd2, 32'hAAAA_AAAA);
    wr(5'd3, 32'h1234_5678);
    wr(5'd31, 32'hDEAD_BEEF);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++)
      check($sformatf("ready_after_rst[%0d]", i), 32'(req_ready[i]), 32'd1);

    foreach (vecs[i])
      do_req(vecs[i].k, vecs[i].addr, vecs[i].bp, vecs[i].exp_data,
             vecs[i].exp_err);

    // LATENCY=1: write to index 2 on the RESP-entry edge
    req_valid[1] = 1'b1;
    req_addr[1]  = 32'h8000_0008;
    mem_we       = 1'b1;
    mem_waddr    = 5'd2;
    mem_wdata    = 32'h5555_5555;
    @(negedge clk);
    req_valid[1] = 1'b0;
    mem_we       = 1'b0;
    check("rbw_valid", 32'(rsp_valid[1]), 32'd1);
    check("rbw_data", rsp_data[1], 32'hAAAA_AAAA);
    rsp_ready[1] = 1'b1;
    @(negedge clk);
    rsp_ready[1] = 1'b0;
    check("rbw_done", 32'(rsp_valid[1]), 32'd0);
    do_req(1, 32'h8000_0008, 0, 32'h5555_5555, 1'b0);

    // asynchronous reset while LATENCY=7 instance waits
    req_valid[2] = 1'b1;
    req_addr[2]  = 32'h8000_0000;
    rsp_ready[2] = 1'b1;
    @(negedge clk);
    req_valid[2] = 1'b0;
    @(negedge clk);
    check("wait_ready", 32'(req_ready[2]), 32'd0);
    #1 rst = 1'b0;
    #1;
    check("arst_valid", 32'(rsp_valid[2]), 32'd0);
    check("arst_err", 32'(rsp_err[2]), 32'd0);
    check("arst_data", rsp_data[2], 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("arst_ready", 32'(req_ready[2]), 32'd1);
    begin
      int stale = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (rsp_valid[2]) stale++;
      end
      check("no_stale_rsp", 32'(stale), 32'd0);
    end
    rsp_ready[2] = 1'b0;
    do_req(2, 32'h8000_0004, 0, 32'h0010_0073, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
